// File: rtl/uart_rx_unit.sv
// 16x-oversampling 8N1 UART receiver, LSB first. A good byte is held on
// rx_data with a one-clock rx_valid strobe; a low stop bit strobes frame_err.
module uart_rx_unit #(
    parameter int DIV = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [3:0] q
);

    localparam int CW = $clog2(DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] div_q;
    logic          tick;
    logic [1:0]    state_q, state_d;
    logic [3:0]    s_q, s_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    // Both synchronizer flops reset high so the idle line never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign tick = (div_q == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset)    div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + CW'(1);
    end

    always_comb begin
        state_d = state_q;
        s_d     = tick ? s_q + 4'd1 : s_q;
        n_d     = n_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    s_d     = 4'd0;
                end
            end
            S_START: begin
                if (tick && s_q == 4'd7) begin
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        s_d     = 4'd0;
                        n_d     = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick && s_q == 4'd15) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    s_d     = 4'd0;
                    if (n_q == 3'd7) state_d = S_STOP;
                    else             n_d     = n_q + 3'd1;
                end
            end
            S_STOP: begin
                if (tick && s_q == 4'd15) begin
                    state_d = S_IDLE;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data   = data_q;
    assign q         = data_q[3:0];
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_unit.md
# uart_rx_unit

UART receiver for the counter/UART top level, the receive-side counterpart of the byte transmitter. It oversamples the asynchronous `rx` line at 16x the baud rate and deserialises 8N1 frames, LSB first. Each good byte is presented with a one-cycle valid strobe and also held. Its low nibble drives the board LEDs. Bad stop bits are flagged and the byte is discarded.

## Interface
- `DIV`, default 27: clocks per oversample tick; 50 MHz / (115200·16) ≈ 27. Legal range is ≥ 2. One bit time = 16·`DIV` clocks.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  one clock; reset is synchronous and active-low (`reset`=0 resets on the next `clk` edge).
- `rx`  input  1  asynchronous serial line; idles high.
- `rx_data`  output  8  last correctly framed byte; held until the next good byte.
- `rx_valid`  output  1  one-clock pulse when `rx_data` is updated.
- `frame_err`  output  1  one-clock pulse when the stop bit samples low.
- `busy`  output  1  high whenever the FSM is not in IDLE.
- `q`  output  4  `rx_data[3:0]`, for the LEDs.

## Operation
- **Input synchronizer**
  - `rx` passes through a 2-flop synchronizer; both flops reset to 1.
  - All decisions use the second flop, `rx_s`.
- **Tick generator**
  - Free-running counter `0..DIV-1`.
  - `tick` pulses for one clock when the count equals `DIV-1`, then wraps to 0.
  - Runs in every state; cleared only by reset.
- **Sample counter `s`** (4 bits): increments on each `tick`.
- **Bit counter `n`** (3 bits): counts data bits.
- **FSM states and transitions**
  - IDLE: while `rx_s`=1 stay. When `rx_s`=0 (falling edge seen), go to START and clear `s`.
  - START: on a `tick` with `s`=7 (mid start bit):
    - `rx_s`=0: clear `s` and `n`, go to DATA.
    - `rx_s`=1: glitch; go to IDLE with no output.
  - DATA: on a `tick` with `s`=15:
    - Shift `rx_s` into the MSB of the shift register (so the byte ends LSB first) and clear `s`.
    - If `n`=7, go to STOP; else increment `n`.
  - STOP: on a `tick` with `s`=15:
    - `rx_s`=1: load `rx_data` from the shift register, pulse `rx_valid`.
    - `rx_s`=0: pulse `frame_err`; `rx_data` is unchanged.
    - Either way go to IDLE.
- **Break / stuck-low line:** after a `frame_err`, IDLE sees `rx_s`=0 immediately and re-enters START. A continuous low line therefore gives one `frame_err` per ~10 bit times, and never `rx_valid`.
- **Reset values:** `rx_data`=0x00, `q`=0x0, `rx_valid`=0, `frame_err`=0, `busy`=0, FSM=IDLE, all counters 0.
- **Reset mid-frame:** the next edge with `reset`=0 aborts the frame. No strobe is issued and the partial byte is lost.
- `rx_valid` and `frame_err` are never high in the same cycle.

## Timing
- `busy` rises 1 clock after `rx_s` falls, i.e. 3 clocks after the `rx` falling edge.
- Data bit k is sampled 16·(k+1)+8 ticks (±1 tick) after start detection, which is mid-bit.
- `rx_valid` / `frame_err` are registered:
  - They assert on the clock after the STOP-state sample tick, about 9.5 bit times after the start edge plus 3 clocks.
  - `busy` falls in that same cycle.
- `rx_data` and `q` change in the same cycle that `rx_valid` is high.
- Start-edge phase uncertainty is ≤ 1 tick (`DIV` clocks). Receiver tolerance is about ±4.5 % baud mismatch.
- A new start bit is accepted from the cycle after the return to IDLE. Back-to-back frames with a single stop bit must be received without loss.

## Test plan
Run with `DIV`=4, so one bit = 64 clocks.
- **Reset:** hold `reset`=0 for 3 clocks with `rx`=1 → all outputs 0; `busy`=0.
- **Single byte:** send 0xA5 (8N1, 64 clk/bit) → exactly one `rx_valid` pulse; `rx_data`=0xA5, `q`=0x5; `frame_err` never high.
- **Back-to-back:** send 0x00, 0xFF, 0x3C with no idle gap → three `rx_valid` pulses; `rx_data` reads 0x00, then 0xFF, then 0x3C; `q` ends at 0xC.
- **Glitch:** drive `rx` low for 20 clocks (less than half a bit), then high → no strobe; `busy` pulses, then returns to 0; `rx_data` unchanged.
- **Framing error:** send 0x5A with stop bit driven low → one `frame_err` pulse; `rx_valid`=0; `rx_data` keeps its previous value.
- **Reset mid-frame:** assert `reset`=0 during data bit 4 of 0x81, then send 0x42 → no strobe for the aborted frame; `rx_data`=0x42 with one `rx_valid`.
